// File: rtl/pipelined_select_addsub.sv
// rtl/pipelined_select_addsub.sv - pipelined carry-select adder/subtractor with valid pipe
// Carry-select blocks are grouped into stages; operands skew forward and sums accumulate.
module pipelined_select_addsub #(
  parameter int BLOCK_SIZE       = 14,
  parameter int NUM_BLOCKS       = 4,
  parameter int BLOCKS_PER_STAGE = 2,
  localparam int DAT_WIDTH       = BLOCK_SIZE * NUM_BLOCKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [DAT_WIDTH-1:0] a,
  input  logic [DAT_WIDTH-1:0] b,
  output logic                 out_valid,
  output logic [DAT_WIDTH:0]   o,
  output logic                 ovf
);

  localparam int NUM_STAGES = (NUM_BLOCKS + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
  localparam int MSB        = DAT_WIDTH - 1;

  logic [DAT_WIDTH-1:0] b_eff;
  assign b_eff = b ^ {DAT_WIDTH{sub}};

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int FIRST_BLK = s * BLOCKS_PER_STAGE;
    localparam int LAST_BLK  = ((s + 1) * BLOCKS_PER_STAGE < NUM_BLOCKS) ?
                               (s + 1) * BLOCKS_PER_STAGE : NUM_BLOCKS;
    localparam int NBS       = LAST_BLK - FIRST_BLK;
    localparam int LO        = FIRST_BLK * BLOCK_SIZE;
    localparam int HI        = LAST_BLK * BLOCK_SIZE;
    localparam int SW        = HI - LO;
    localparam int RW        = DAT_WIDTH - LO;

    logic [RW-1:0]  a_in;
    logic [RW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic           a_sgn_in;
    logic           b_sgn_in;
    logic [SW-1:0]  sum_c;
    logic [HI-1:0]  sum_full;
    logic [NBS:0]   carry;

    logic [HI-1:0]  sum_r;
    logic           carry_r;
    logic           valid_r;
    logic           a_sgn_r;
    logic           b_sgn_r;

    if (s == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b_eff;
      assign c_in     = cin;
      assign v_in     = in_valid;
      assign a_sgn_in = a[MSB];
      assign b_sgn_in = b_eff[MSB];
      assign sum_full = sum_c;
    end else begin : g_tail
      assign a_in     = g_stage[s-1].g_rem.a_rem_r;
      assign b_in     = g_stage[s-1].g_rem.b_rem_r;
      assign c_in     = g_stage[s-1].carry_r;
      assign v_in     = g_stage[s-1].valid_r;
      assign a_sgn_in = g_stage[s-1].a_sgn_r;
      assign b_sgn_in = g_stage[s-1].b_sgn_r;
      // Lower sum bits from earlier stages ride along so all bits leave together.
      assign sum_full = {sum_c, g_stage[s-1].sum_r};
    end

    assign carry[0] = c_in;

    for (genvar j = 0; j < NBS; j++) begin : g_blk
      logic [BLOCK_SIZE-1:0] ab;
      logic [BLOCK_SIZE-1:0] bb;
      assign ab = a_in[j*BLOCK_SIZE +: BLOCK_SIZE];
      assign bb = b_in[j*BLOCK_SIZE +: BLOCK_SIZE];

      if (FIRST_BLK + j == 0) begin : g_ripple
        assign {carry[j+1], sum_c[j*BLOCK_SIZE +: BLOCK_SIZE]} =
          {1'b0, ab} + {1'b0, bb} + {{BLOCK_SIZE{1'b0}}, carry[j]};
      end else begin : g_select
        logic [BLOCK_SIZE:0] r0;
        logic [BLOCK_SIZE:0] r1;
        assign r0 = {1'b0, ab} + {1'b0, bb};
        assign r1 = {1'b0, ab} + {1'b0, bb} + {{BLOCK_SIZE{1'b0}}, 1'b1};
        assign {carry[j+1], sum_c[j*BLOCK_SIZE +: BLOCK_SIZE]} = carry[j] ? r1 : r0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_r   <= '0;
        carry_r <= 1'b0;
        valid_r <= 1'b0;
        a_sgn_r <= 1'b0;
        b_sgn_r <= 1'b0;
      end else if (ce) begin
        sum_r   <= sum_full;
        carry_r <= carry[NBS];
        valid_r <= v_in;
        a_sgn_r <= a_sgn_in;
        b_sgn_r <= b_sgn_in;
      end
    end

    if (s < NUM_STAGES - 1) begin : g_rem
      logic [DAT_WIDTH-HI-1:0] a_rem_r;
      logic [DAT_WIDTH-HI-1:0] b_rem_r;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_rem_r <= '0;
          b_rem_r <= '0;
        end else if (ce) begin
          a_rem_r <= a_in[RW-1:SW];
          b_rem_r <= b_in[RW-1:SW];
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_STAGES-1].valid_r;
  assign o         = {g_stage[NUM_STAGES-1].carry_r, g_stage[NUM_STAGES-1].sum_r};
  assign ovf       = (g_stage[NUM_STAGES-1].a_sgn_r == g_stage[NUM_STAGES-1].b_sgn_r) &&
                     (g_stage[NUM_STAGES-1].sum_r[MSB] != g_stage[NUM_STAGES-1].a_sgn_r);

endmodule

// File: tb/tb_pipelined_select_addsub.sv
// tb/tb_pipelined_select_addsub.sv - directed and random checks for pipelined_select_addsub
module tb_pipelined_select_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        sub;
  logic        cin;
  logic [55:0] a;
  logic [55:0] b;
  logic        out_valid;
  logic [56:0] o;
  logic        ovf;

  logic        ce2;
  logic        iv2;
  logic        sub2;
  logic        cin2;
  logic [39:0] a2;
  logic [39:0] b2;
  logic        ov2;
  logic [40:0] o2;
  logic        ovf2;

  int tests_run    = 0;
  int tests_failed = 0;

  pipelined_select_addsub dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sub(sub), .cin(cin),
    .a(a), .b(b), .out_valid(out_valid), .o(o), .ovf(ovf)
  );

  pipelined_select_addsub #(.BLOCK_SIZE(8), .NUM_BLOCKS(5), .BLOCKS_PER_STAGE(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce2), .in_valid(iv2), .sub(sub2), .cin(cin2),
    .a(a2), .b(b2), .out_valid(ov2), .o(o2), .ovf(ovf2)
  );

  task automatic set_op(input logic v, input logic s, input logic c,
                        input logic [55:0] aa, input logic [55:0] bb);
    in_valid = v;
    sub      = s;
    cin      = c;
    a        = aa;
    b        = bb;
  endtask

  task automatic run_op(input logic s, input logic c,
                        input logic [55:0] aa, input logic [55:0] bb);
    set_op(1'b1, s, c, aa, bb);
    @(negedge clk);
    set_op(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] r;
    rst = 1'b1;
    ce  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = {$urandom(), $urandom()};
      set_op(1'b1, r[60], r[61], r[55:0], ~r[55:0]);
      @(negedge clk);
      tests_run++;
      if (o !== '0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state cycle %0d: o=%h ovf=%b out_valid=%b, expected 0/0/0", i, o, ovf, out_valid);
      end
    end
    rst = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_flush cycle %0d: out_valid=%b, expected 0", i, out_valid);
      end
    end
    set_op(1'b1, 1'b0, 1'b0, 56'd1, 56'd1);
    @(negedge clk);
    set_op(1'b0, 1'b0, 1'b0, '0, '0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_valid_early: out_valid=%b after 1 cycle, expected 0", out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || o !== 57'd2) begin
      tests_failed++;
      $display("FAIL first_valid_latency: out_valid=%b o=%h, expected 1 / 2", out_valid, o);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_valid_single: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_carry_ripple();
    run_op(1'b0, 1'b0, 56'hFFFFFFFFFFFFFF, 56'h1);
    tests_run++;
    if (out_valid !== 1'b1 || o !== 57'h100000000000000 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL carry_ripple: v=%b o=%h ovf=%b, expected 1 / 100000000000000 / 0", out_valid, o, ovf);
    end
  endtask

  task automatic test_subtract_borrow();
    run_op(1'b1, 1'b1, 56'd5, 56'd7);
    tests_run++;
    if (o !== 57'h0FFFFFFFFFFFFFE || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_borrow: o=%h ovf=%b, expected 0fffffffffffffe / 0", o, ovf);
    end
  endtask

  task automatic test_overflow();
    run_op(1'b0, 1'b0, 56'h7FFFFFFFFFFFFF, 56'h1);
    tests_run++;
    if (o !== 57'h080000000000000 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_add: o=%h ovf=%b, expected 080000000000000 / 1", o, ovf);
    end
    run_op(1'b1, 1'b1, 56'h80000000000000, 56'h1);
    tests_run++;
    if (o !== 57'h17FFFFFFFFFFFFF || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sub: o=%h ovf=%b, expected 17fffffffffffff / 1", o, ovf);
    end
  endtask

  task automatic test_ce_stall();
    logic [56:0] exp_o [8];
    logic        exp_v [8];
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_o = '{57'h0, 57'h3, 57'h3, 57'h3, 57'h100000000000007,
              57'h1FFFFFFFFFFFFFF, 57'h2000, 57'h0};
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       begin ce = 1'b1; set_op(1'b1, 1'b0, 1'b0, 56'd1, 56'd2); end
        1:       begin ce = 1'b1; set_op(1'b1, 1'b1, 1'b1, 56'd10, 56'd3); end
        2, 3:    begin ce = 1'b0; set_op(1'b1, 1'b0, 1'b0, 56'h55555555555555, 56'h33); end
        4:       begin ce = 1'b1; set_op(1'b1, 1'b0, 1'b1, '1, '1); end
        5:       begin ce = 1'b1; set_op(1'b1, 1'b0, 1'b1, 56'h1000, 56'hFFF); end
        default: begin ce = 1'b1; set_op(1'b0, 1'b0, 1'b0, '0, '0); end
      endcase
      @(negedge clk);
      tests_run++;
      if (out_valid !== exp_v[k] || (exp_v[k] && o !== exp_o[k])) begin
        tests_failed++;
        $display("FAIL ce_stall step %0d: v=%b o=%h, expected %b / %h", k, out_valid, o, exp_v[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_random_partial_stage();
    logic [63:0] r;
    logic [63:0] q;
    logic [39:0] bx;
    logic [40:0] full;
    logic [40:0] m_o   [3];
    logic        m_v   [3];
    logic        m_ovf [3];
    for (int i = 0; i < 3; i++) begin
      m_o[i] = '0; m_v[i] = 1'b0; m_ovf[i] = 1'b0;
    end
    for (int n = 0; n < 10000; n++) begin
      r    = {$urandom(), $urandom()};
      q    = {$urandom(), $urandom()};
      a2   = r[39:0];
      b2   = q[39:0];
      sub2 = r[40];
      cin2 = r[41];
      iv2  = r[42];
      ce2  = |r[44:43];
      if (ce2) begin
        bx   = b2 ^ {40{sub2}};
        full = {1'b0, a2} + {1'b0, bx} + {40'd0, cin2};
        m_v[2] = m_v[1];  m_o[2] = m_o[1];  m_ovf[2] = m_ovf[1];
        m_v[1] = m_v[0];  m_o[1] = m_o[0];  m_ovf[1] = m_ovf[0];
        m_v[0] = iv2;     m_o[0] = full;
        m_ovf[0] = (a2[39] == bx[39]) && (full[39] != a2[39]);
      end
      @(negedge clk);
      tests_run++;
      if (ov2 !== m_v[2] || (m_v[2] && (o2 !== m_o[2] || ovf2 !== m_ovf[2]))) begin
        tests_failed++;
        $display("FAIL random vec %0d: v=%b o=%h ovf=%b, expected %b / %h / %b",
                 n, ov2, o2, ovf2, m_v[2], m_o[2], m_ovf[2]);
      end
    end
    iv2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, '0, '0);
    ce2 = 1'b1; iv2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    test_reset();
    test_carry_ripple();
    test_subtract_borrow();
    test_overflow();
    test_ce_stall();
    test_random_partial_stage();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
